// File: rtl/ctrl_sequencer.sv
// Microcode control sequencer: T-state counter plus combinational decode of
// step, opcode and flags into the bus control strobes of the 8-bit CPU.
module ctrl_sequencer #(
   parameter int OPC_W         = 4,
   parameter int STEP_W        = 3,
   parameter int HALT_ON_UNDEF = 0
) (
   input  logic              clk,
   input  logic              clr_n,
   input  logic [OPC_W-1:0]  opcode,
   input  logic              flag_c,
   input  logic              flag_z,
   output logic [STEP_W-1:0] step,
   output logic              halted,
   output logic              hlt,
   output logic              co_n,
   output logic              mi_n,
   output logic              ro_n,
   output logic              ri_n,
   output logic              io_n,
   output logic              ii_n,
   output logic              ai_n,
   output logic              ao_n,
   output logic              eo_n,
   output logic              bi_n,
   output logic              oi_n,
   output logic              j_n,
   output logic              fi_n,
   output logic              ce,
   output logic              su
);

   typedef enum logic [STEP_W-1:0] {T0, T1, T2, T3, T4} t_step_e;

   localparam logic [OPC_W-1:0] OP_NOP = OPC_W'(4'h0);
   localparam logic [OPC_W-1:0] OP_LDA = OPC_W'(4'h1);
   localparam logic [OPC_W-1:0] OP_ADD = OPC_W'(4'h2);
   localparam logic [OPC_W-1:0] OP_SUB = OPC_W'(4'h3);
   localparam logic [OPC_W-1:0] OP_STA = OPC_W'(4'h4);
   localparam logic [OPC_W-1:0] OP_LDI = OPC_W'(4'h5);
   localparam logic [OPC_W-1:0] OP_JMP = OPC_W'(4'h6);
   localparam logic [OPC_W-1:0] OP_JC  = OPC_W'(4'h7);
   localparam logic [OPC_W-1:0] OP_JZ  = OPC_W'(4'h8);
   localparam logic [OPC_W-1:0] OP_OUT = OPC_W'(4'hE);
   localparam logic [OPC_W-1:0] OP_HLT = OPC_W'(4'hF);

   t_step_e step_q, step_nx;
   logic    halted_q, halted_nx;
   logic    is_undef, halt_op, last;

   always_ff @(posedge clk) begin
      if (!clr_n) begin
         step_q   <= T0;
         halted_q <= 1'b0;
      end else begin
         step_q   <= step_nx;
         halted_q <= halted_nx;
      end
   end

   always_comb begin
      is_undef = 1'b0;
      case (opcode)
         OP_NOP, OP_LDA, OP_ADD, OP_SUB, OP_STA, OP_LDI,
         OP_JMP, OP_JC, OP_JZ, OP_OUT, OP_HLT: is_undef = 1'b0;
         default:                              is_undef = 1'b1;
      endcase
      halt_op = (opcode == OP_HLT) || (is_undef && (HALT_ON_UNDEF != 0));
   end

   always_comb begin
      co_n = 1'b1; mi_n = 1'b1; ro_n = 1'b1; ri_n = 1'b1; io_n = 1'b1;
      ii_n = 1'b1; ai_n = 1'b1; ao_n = 1'b1; eo_n = 1'b1; bi_n = 1'b1;
      oi_n = 1'b1; j_n  = 1'b1; fi_n = 1'b1;
      ce   = 1'b0; su   = 1'b0; hlt  = 1'b0;
      last      = 1'b0;
      step_nx   = t_step_e'(step_q + 1'b1);
      halted_nx = halted_q;

      if (halted_q) begin
         step_nx = T0;
      end else begin
         case (step_q)
            T0: begin
               co_n = 1'b0; mi_n = 1'b0;
            end
            T1: begin
               ro_n = 1'b0; ii_n = 1'b0; ce = 1'b1;
            end
            T2: begin
               last = 1'b1;
               case (opcode)
                  OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
                     io_n = 1'b0; mi_n = 1'b0; last = 1'b0;
                  end
                  OP_LDI: begin io_n = 1'b0; ai_n = 1'b0; end
                  OP_JMP: begin io_n = 1'b0; j_n  = 1'b0; end
                  OP_JC:  begin io_n = ~flag_c; j_n = ~flag_c; end
                  OP_JZ:  begin io_n = ~flag_z; j_n = ~flag_z; end
                  OP_OUT: begin ao_n = 1'b0; oi_n = 1'b0; end
                  default: hlt = halt_op;
               endcase
               if (halt_op) halted_nx = 1'b1;
            end
            T3: begin
               last = 1'b1;
               case (opcode)
                  OP_LDA: begin ro_n = 1'b0; ai_n = 1'b0; end
                  OP_STA: begin ao_n = 1'b0; ri_n = 1'b0; end
                  OP_ADD, OP_SUB: begin
                     ro_n = 1'b0; bi_n = 1'b0; last = 1'b0;
                  end
                  default: ;
               endcase
            end
            T4: begin
               last = 1'b1;
               if (opcode == OP_ADD || opcode == OP_SUB) begin
                  eo_n = 1'b0; ai_n = 1'b0; fi_n = 1'b0;
                  su   = (opcode == OP_SUB);
               end
            end
            default: last = 1'b1;
         endcase
         if (last) step_nx = T0;
      end

      // Reset overrides the decode so nothing drives the bus during clear.
      if (!clr_n) begin
         co_n = 1'b1; mi_n = 1'b1; ro_n = 1'b1; ri_n = 1'b1; io_n = 1'b1;
         ii_n = 1'b1; ai_n = 1'b1; ao_n = 1'b1; eo_n = 1'b1; bi_n = 1'b1;
         oi_n = 1'b1; j_n  = 1'b1; fi_n = 1'b1;
         ce   = 1'b0; su   = 1'b0; hlt  = 1'b0;
      end
   end

   assign step   = step_q;
   assign halted = halted_q;

endmodule

// File: doc/ctrl_sequencer.md
Name: ctrl_sequencer

Overview:
- Microcode control sequencer for the 8-bit bus CPU.
- Holds a T-state step counter and decodes the step, the IR opcode and the ALU flags into the per-register bus control strobes: the active-low in/out enables of registers A/B, MAR, RAM, IR and OUT, plus the PC and ALU controls.
- Sequences the fetch and execute of every instruction.
- Guarantees a single bus driver per cycle.

Parameters:
- OPC_W, 4, opcode width (IR upper nibble).
- STEP_W, 3, step counter width; steps T0..T4 used.
- HALT_ON_UNDEF, 0, 1 = undefined opcodes behave as HLT; 0 = behave as NOP.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- clr_n  in  1  synchronous active-low reset.
- opcode  in  OPC_W  instruction opcode from IR.
- flag_c  in  1  registered carry flag.
- flag_z  in  1  registered zero flag.
- step  out  STEP_W  current T-state, 0..4.
- halted  out  1  high once HLT has executed.
- hlt  out  1  halt strobe (high in the HLT execute step).
- co_n, mi_n, ro_n, ri_n, io_n, ii_n, ai_n, ao_n, eo_n, bi_n, oi_n, j_n, fi_n  out  1 each  active-low strobes:
  - PC out, MAR in, RAM out, RAM in, IR operand out, IR in, A in, A out, ALU out, B in, OUT in, PC load, flags in.
- ce  out  1  PC count enable, active-high.
- su  out  1  ALU subtract select, active-high.

Behaviour:
- Reset: clr_n low at a posedge sets step=0 and halted=0.
- While clr_n is low, all strobes are forced inactive combinationally: _n outputs=1, ce=su=hlt=0.
- State registers are step and halted only. Strobes are a combinational decode of (step, halted, opcode, flags).
- Fetch, all opcodes:
  - T0: co_n=0, mi_n=0.
  - T1: ro_n=0, ii_n=0, ce=1. IR captures the opcode at the end of T1; the opcode is valid from T2.
- Execute, by opcode (hex):
  - LDA 1: T2 io_n,mi_n; T3 ro_n,ai_n.
  - ADD 2: T2 io_n,mi_n; T3 ro_n,bi_n; T4 eo_n,ai_n,fi_n.
  - SUB 3: as ADD, plus su=1 in T4.
  - STA 4: T2 io_n,mi_n; T3 ao_n,ri_n.
  - LDI 5: T2 io_n,ai_n.
  - JMP 6: T2 io_n,j_n.
  - JC 7: T2 io_n,j_n only if flag_c=1, else no strobes.
  - JZ 8: as JC using flag_z.
  - OUT E: T2 ao_n,oi_n.
  - HLT F: T2 hlt=1.
  - NOP 0 and undefined: T2 no strobes, or HLT behaviour if HALT_ON_UNDEF=1.
- Step advance: step increments each cycle. After the last step of the current instruction, step returns to 0.
- Last step per instruction:
  - LDA, STA: T3.
  - ADD, SUB: T4.
  - All others: T2.
- A not-taken JC/JZ still occupies T2.
- Halt: on the edge ending a HLT T2, halted<=1 and step<=0.
- While halted=1: step holds 0, all strobes are inactive, hlt=0. Only clr_n exits halt.
- Bus exclusivity: at most one of co_n, ro_n, io_n, ao_n, eo_n is low in any cycle. A bench assertion checks this every cycle.
- Reset mid-instruction: abandons the instruction; the next cycle is T0 fetch.
- Opcode changes are only used from T2 on. Opcode changes during T0/T1 have no effect on strobes.

Test Plan:
- clr_n=0 for 2 cycles, then 1 -> step=0, halted=0, all _n=1 while in reset; the first cycle after release shows co_n=0, mi_n=0.
- opcode=2 (ADD), flags 0 -> steps 0,1,2,3,4,0. T4 has eo_n=0, ai_n=0, fi_n=0, su=0. Bus exclusivity holds throughout.
- opcode=3 (SUB) -> identical sequence to ADD with su=1 only in T4. opcode=4 (STA) -> T3 ao_n=0, ri_n=0, then step=0.
- opcode=7 with flag_c=0 -> T2 has all strobes inactive, then step=0. With flag_c=1 -> T2 io_n=0, j_n=0.
- opcode=F -> T2 hlt=1, then halted=1 and step frozen at 0 for 10 cycles with no strobes. Pulsing clr_n low resumes fetch.
- clr_n low during ADD T3 -> next cycle step=0, fetch T0 strobes. opcode=A with HALT_ON_UNDEF=1 -> halts; with 0 -> 3-step NOP.
